// File: rtl/shift_reg_pkg.sv
// rtl/shift_reg_pkg.sv - mode encodings shared by all users of the universal shift register
package shift_reg_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHL  = 2'b01;
  localparam logic [1:0] MODE_SHR  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

endpackage

// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - universal shift register with shift counter; UNIV_SHIFT_ROTATE_EN enables rotate
module univ_shift_reg
  import shift_reg_pkg::*;
#(
  parameter int              WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int             CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic [1:0]       mode_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             sin_i,
  input  logic             rot_i,
  output logic [WIDTH-1:0] q_o,
  output logic             sout_msb_o,
  output logic             sout_lsb_o,
  output logic [CNT_W-1:0] shift_cnt_o,
  output logic             done_o
);

  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q;
  logic             done_q;
  logic             fill_l, fill_r;
  logic             is_shift;

`ifndef UNIV_SHIFT_ROTATE_EN
  // rot is kept on the port list so both builds share one footprint
  logic unused_rot;
  assign unused_rot = rot_i;
`endif

  assign is_shift = (mode_i == MODE_SHL) || (mode_i == MODE_SHR);

  // Next register value: pick fill bits, then apply the selected mode
  always_comb begin
    fill_l = sin_i;
    fill_r = sin_i;
`ifdef UNIV_SHIFT_ROTATE_EN
    if (rot_i) begin
      fill_l = q_q[WIDTH-1];
      fill_r = q_q[0];
    end
`endif
    q_d = q_q;
    case (mode_i)
      MODE_SHL:  q_d = {q_q[WIDTH-2:0], fill_l};
      MODE_SHR:  q_d = {fill_r, q_q[WIDTH-1:1]};
      MODE_LOAD: q_d = d_i;
      default:   q_d = q_q;
    endcase
  end

  // Data register: reset overrides enable, en=0 freezes contents
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      q_q <= RESET_VAL;
    end else if (en_i) begin
      q_q <= q_d;
    end
  end

  // Shift counter: wraps after WIDTH shifts and pulses done with the last shifted value
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (en_i) begin
        if (mode_i == MODE_LOAD) begin
          cnt_q <= '0;
        end else if (is_shift) begin
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            cnt_q  <= '0;
            done_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
      end
    end
  end

  assign q_o         = q_q;
  assign sout_msb_o  = q_q[WIDTH-1];
  assign sout_lsb_o  = q_q[0];
  assign shift_cnt_o = cnt_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb/tb_univ_shift_reg.sv - self-checking bench for univ_shift_reg against an arithmetic reference model
module tb_univ_shift_reg;
  import shift_reg_pkg::*;

  localparam int         W    = 8;
  localparam logic [7:0] RVAL = 8'h00;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic [1:0] mode = MODE_HOLD;
  logic [7:0] d = '0;
  logic       sin = 1'b0;
  logic       rot = 1'b0;
  logic [7:0] q;
  logic       sout_msb, sout_lsb;
  logic [3:0] shift_cnt;
  logic       done;

  int checks = 0;
  int errors = 0;

  // reference model state: value, shifts since last load/reset, done flag
  int m_val;
  int m_shifts;
  bit m_done;

  univ_shift_reg #(.WIDTH(W), .RESET_VAL(RVAL)) dut (
    .clk_i(clk), .reset_i(reset), .en_i(en), .mode_i(mode), .d_i(d),
    .sin_i(sin), .rot_i(rot), .q_o(q), .sout_msb_o(sout_msb),
    .sout_lsb_o(sout_lsb), .shift_cnt_o(shift_cnt), .done_o(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // model of one rising edge, written from the arithmetic meaning of each mode
  task automatic model_edge();
    int fill;
    m_done = 1'b0;
    if (reset) begin
      m_val    = int'(RVAL);
      m_shifts = 0;
    end else if (en) begin
      fill = int'(sin);
`ifdef UNIV_SHIFT_ROTATE_EN
      if (rot) fill = (mode == MODE_SHL) ? (m_val / 128) % 2 : m_val % 2;
`endif
      if (mode == MODE_SHL) begin
        m_val = (m_val * 2 + fill) % 256;
        m_shifts++;
        m_done = (m_shifts % W) == 0;
      end else if (mode == MODE_SHR) begin
        m_val = m_val / 2 + fill * 128;
        m_shifts++;
        m_done = (m_shifts % W) == 0;
      end else if (mode == MODE_LOAD) begin
        m_val    = int'(d);
        m_shifts = 0;
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".q"},    32'(q),         32'(m_val));
    chk({tag, ".msb"},  32'(sout_msb),  32'(m_val / 128));
    chk({tag, ".lsb"},  32'(sout_lsb),  32'(m_val % 2));
    chk({tag, ".cnt"},  32'(shift_cnt), 32'(m_shifts % W));
    chk({tag, ".done"}, 32'(done),      32'(m_done));
  endtask

  task automatic step(input string tag, input bit r, input bit e, input logic [1:0] md,
                      input logic [7:0] dd, input bit s, input bit rt);
    reset = r; en = e; mode = md; d = dd; sin = s; rot = rt;
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  logic [7:0] shl_exp [8];
  logic [7:0] rot_exp;

  initial begin
    shl_exp = '{8'h4B, 8'h97, 8'h2F, 8'h5F, 8'hBF, 8'h7F, 8'hFF, 8'hFF};
`ifdef UNIV_SHIFT_ROTATE_EN
    rot_exp = 8'hC0;
`else
    rot_exp = 8'h40;
`endif
    m_val = 0; m_shifts = 0; m_done = 1'b0;

    // 1: reset wins over an enabled load
    for (int i = 0; i < 3; i++) begin
      step("reset", 1, 1, MODE_LOAD, 8'hFF, 0, 0);
      chk("reset.q_const", 32'(q), 32'h00);
    end

    // 2: parallel load
    step("load_a5", 0, 1, MODE_LOAD, 8'hA5, 0, 0);
    chk("load_a5.q_const", 32'(q), 32'hA5);

    // 3: eight left shifts, done only with the eighth value
    for (int i = 0; i < 8; i++) begin
      step("shl", 0, 1, MODE_SHL, 8'h00, 1, 0);
      chk("shl.q_const", 32'(q), 32'(shl_exp[i]));
      chk("shl.done_const", 32'(done), (i == 7) ? 32'd1 : 32'd0);
    end
    chk("shl.cnt_wrap", 32'(shift_cnt), 32'd0);

    // 4: enable low freezes state
    step("pre_freeze", 0, 1, MODE_SHR, 8'h00, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step("freeze", 0, 0, MODE_SHR, 8'h00, 0, 0);
      chk("freeze.q_const", 32'(q), 32'h7F);
      chk("freeze.cnt_const", 32'(shift_cnt), 32'd1);
    end

    // 5: reset in the middle of a shift run discards the count
    step("load_3c", 0, 1, MODE_LOAD, 8'h3C, 0, 0);
    for (int i = 0; i < 3; i++) step("shr3", 0, 1, MODE_SHR, 8'h00, 0, 0);
    step("mid_reset", 1, 1, MODE_SHR, 8'h00, 0, 0);
    chk("mid_reset.q_const", 32'(q), 32'h00);
    chk("mid_reset.done_const", 32'(done), 32'd0);

    // 6: rotate select on a right shift
    step("load_81", 0, 1, MODE_LOAD, 8'h81, 0, 0);
    step("rot_shr", 0, 1, MODE_SHR, 8'h00, 0, 1);
    chk("rot_shr.q_const", 32'(q), 32'(rot_exp));

    // direction change keeps counting: 4 SHL + 4 SHR wraps
    step("load_5a", 0, 1, MODE_LOAD, 8'h5A, 0, 0);
    for (int i = 0; i < 8; i++)
      step("mixdir", 0, 1, (i < 4) ? MODE_SHL : MODE_SHR, 8'h00, i[0], 0);
    chk("mixdir.done_const", 32'(done), 32'd1);

    // randomized run against the model
    for (int i = 0; i < 400; i++) begin
      logic [1:0] md;
      md = 2'($urandom_range(0, 3));
      if (md == MODE_LOAD && $urandom_range(0, 3) != 0) md = MODE_SHL;
      step("rand", $urandom_range(0, 39) == 0, $urandom_range(0, 7) != 0, md,
           8'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
